// File: rtl/result_sram_drain.sv
// Streams an m x p FP32 result matrix out of the result SRAM, row-major, over valid/ready.
// Optional macro RESULT_DRAIN_NONFINITE_EN adds per-beat Inf/NaN flagging and a per-drain count.
module result_sram_drain #(
  parameter int          ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          DIM_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  m_dim,
  input  logic [DIM_W-1:0]  p_dim,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_read_address,
  input  logic [31:0]       sram_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [DIM_W-1:0]  out_row,
  output logic [DIM_W-1:0]  out_col,
  output logic              out_last
`ifdef RESULT_DRAIN_NONFINITE_EN
  ,
  output logic              out_nonfinite,
  output logic [DIM_W-1:0]  nonfinite_cnt
`endif
);

  localparam int                TW        = 2 * DIM_W;
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

  typedef struct packed {
    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
    logic             last;
  } tag_t;

  typedef struct packed {
    logic [31:0] data;
    tag_t        tag;
  } beat_t;

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  m_q, m_d, p_q, p_d;
  logic [DIM_W-1:0]  row_q, row_d, col_q, col_d;
  logic [TW-1:0]     total_q, total_d, idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;
  tag_t              infl_tag_q, infl_tag_d;
  beat_t             head_q, head_d, tail_q, tail_d;
  logic [1:0]        count_q, count_d;

  logic              idle, start_acc, issue, push, pop, credit_ok;
  logic [2:0]        load;
  logic [TW-1:0]     total_in, iss_idx;
  logic [DIM_W-1:0]  iss_row, iss_col, iss_m_last, iss_p_last;
  tag_t              iss_tag;
  beat_t             push_beat;

  assign idle      = (state_q == S_IDLE);
  assign start_acc = idle && start;
  assign total_in  = TW'(m_dim) * TW'(p_dim);

  // The head entry of the FIFO drives the output port directly.
  assign pop  = (count_q != 2'd0) && out_ready;
  assign push = inflight_q;

  // A new read may go out only if it still fits once everything in flight lands.
  assign load      = {1'b0, count_q} + {2'b00, inflight_q};
  assign credit_ok = load < (3'd2 + {2'b00, pop});

  // The start edge itself issues element (0,0): the address already sits at the base in IDLE.
  assign iss_row    = idle ? '0 : row_q;
  assign iss_col    = idle ? '0 : col_q;
  assign iss_idx    = idle ? '0 : idx_q;
  assign iss_m_last = (idle ? m_dim : m_q) - DIM_W'(1);
  assign iss_p_last = (idle ? p_dim : p_q) - DIM_W'(1);

  assign issue = (start_acc && (total_in != '0)) ||
                 ((state_q == S_RUN) && (idx_q < total_q) && credit_ok);

  always_comb begin
    iss_tag.row  = iss_row;
    iss_tag.col  = iss_col;
    iss_tag.last = (iss_row == iss_m_last) && (iss_col == iss_p_last);
  end

  always_comb begin
    push_beat.data = sram_read_data;
    push_beat.tag  = infl_tag_q;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    m_d        = m_q;
    p_d        = p_q;
    total_d    = total_q;
    idx_d      = idx_q;
    row_d      = row_q;
    col_d      = col_q;
    addr_d     = addr_q;
    inflight_d = issue;
    infl_tag_d = infl_tag_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (start_acc) begin
      m_d     = m_dim;
      p_d     = p_dim;
      total_d = total_in;
    end

    if (issue) begin
      idx_d      = iss_idx + TW'(1);
      addr_d     = addr_q + ADDR_W'(1);
      infl_tag_d = iss_tag;
      if (iss_col == iss_p_last) begin
        col_d = '0;
        row_d = iss_row + DIM_W'(1);
      end else begin
        col_d = iss_col + DIM_W'(1);
        row_d = iss_row;
      end
    end else if (start_acc) begin
      idx_d = '0;
      row_d = '0;
      col_d = '0;
    end

    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_beat;
        else                 tail_d = push_beat;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) head_d = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          head_d = tail_q;
          tail_d = push_beat;
        end else begin
          head_d = push_beat;
        end
      end
      default: ;
    endcase

    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        if (total_q == '0)         state_d = S_DONE;
        else if (idx_q == total_q) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop)))
          state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        addr_d  = ADDR_BASE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the two FIFO entries are reset with the control state; out_data must read 0 after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      m_q        <= '0;
      p_q        <= '0;
      total_q    <= '0;
      idx_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= ADDR_BASE;
      inflight_q <= 1'b0;
      infl_tag_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      state_q    <= state_d;
      m_q        <= m_d;
      p_q        <= p_d;
      total_q    <= total_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      infl_tag_q <= infl_tag_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  assign busy              = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done              = (state_q == S_DONE);
  assign sram_read_address = addr_q;
  assign out_valid         = (count_q != 2'd0);
  assign out_data          = head_q.data;
  assign out_row           = head_q.tag.row;
  assign out_col           = head_q.tag.col;
  assign out_last          = head_q.tag.last;

`ifdef RESULT_DRAIN_NONFINITE_EN
  logic [DIM_W-1:0] nf_cnt_q, nf_cnt_d;

  assign out_nonfinite = out_valid && (head_q.data[30:23] == 8'hFF);
  assign nonfinite_cnt = nf_cnt_q;

  // Counts handshaken Inf/NaN beats, saturating; holds after done until the next start.
  always_comb begin
    nf_cnt_d = nf_cnt_q;
    if (start_acc)
      nf_cnt_d = '0;
    else if (pop && out_nonfinite && (nf_cnt_q != '1))
      nf_cnt_d = nf_cnt_q + DIM_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) nf_cnt_q <= '0;
    else          nf_cnt_q <= nf_cnt_d;
  end
`endif

endmodule
